// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
//   Shared types for the LED pattern generator.
//   - led_mode_t  : mode encoding used on the command port and on o_mode
//                   (0 OFF, 1 ON, 2 BLINK, 3 BREATHE).
//   - led_state_t : command FSM states (RUN accepts commands, APPLY installs one).
//   - LED_MODE_W  : width of the mode field.
// -----------------------------------------------------------------------------
package led_pkg;

    localparam int LED_MODE_W = 2;

    typedef enum logic [LED_MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } led_mode_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_APPLY = 1'b1
    } led_state_t;

endpackage

// File: rtl/led_prescaler.sv
// -----------------------------------------------------------------------------
// led_prescaler
//   Divides the system clock into slow ticks. The counter runs 0..PRESCALE-1
//   and wraps; o_tick is high in the wrap cycle, so PRESCALE=1 ticks every
//   cycle.
//   Ports:
//     i_clock   - system clock
//     i_reset_n - asynchronous active-low reset
//     i_clear   - synchronous clear; counter restarts at 0 on the next edge
//     o_tick    - single-cycle tick in the wrap cycle
// -----------------------------------------------------------------------------
module led_prescaler #(
    parameter int PRESCALE = 1000
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign o_tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (i_clear || o_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
//   LED pattern generator feeding led_control (o_led -> i_clock,
//   o_gnd -> i_gnd). A command port selects OFF, ON, BLINK (square wave with a
//   half-period of PRESCALE*BLINK_TICKS cycles) or BREATHE (PWM ramp whose duty
//   climbs 0..2^PWM_BITS-1 and back, one step per tick).
//
//   Build option: define LED_BREATHE_EN to build BREATHE mode. Without it,
//   mode 3 is still handshaken but rejected: o_mode and the running pattern
//   are untouched and o_err pulses for the APPLY cycle.
//
//   Handshake: a command transfers on a rising edge where i_cmd_valid and
//   o_cmd_ready are both high. o_cmd_ready is decoded from FSM state only
//   (high in RUN, low in APPLY); valid while not ready is ignored and the
//   requester keeps valid high until it is accepted.
//
//   Ports:
//     i_clock, i_reset_n        - clock, asynchronous active-low reset
//     i_cmd_valid, o_cmd_ready  - command handshake
//     i_cmd_mode                - requested mode
//     o_led                     - registered LED drive
//     o_gnd                     - LED return, constant 0
//     o_mode                    - active mode
//     o_err                     - one-cycle pulse for a rejected mode
//     o_dbg_state               - FSM state, for observation only
// -----------------------------------------------------------------------------
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int PRESCALE    = 1000,
    parameter int BLINK_TICKS = 250,
    parameter int PWM_BITS    = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [LED_MODE_W-1:0] i_cmd_mode,
    output logic                  o_led,
    output logic                  o_gnd,
    output logic [LED_MODE_W-1:0] o_mode,
    output logic                  o_err,
    output led_state_t            o_dbg_state
);

    localparam int TW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

`ifdef LED_BREATHE_EN
    localparam logic BREATHE_BUILT = 1'b1;
`else
    localparam logic BREATHE_BUILT = 1'b0;
`endif

    // Elaboration-time guard on the parameter ranges.
    if (PRESCALE < 1 || BLINK_TICKS < 1 || PWM_BITS < 1) begin : g_param_check
        $error("led_pattern_gen: PRESCALE, BLINK_TICKS and PWM_BITS must be >= 1");
    end

    led_state_t    state_q, state_d;
    led_mode_t     mode_q, mode_d;
    logic          apply_ok_q, apply_ok_d;   // APPLY in progress installs a new mode
    logic          err_q, err_d;
    logic          led_q, led_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          phase_q, phase_d;
    logic          tick;
    logic          presc_clear;
    logic          cmd_supported;
    logic          blank;

`ifdef LED_BREATHE_EN
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                dir_up_q, dir_up_d;
`endif

    assign cmd_supported = BREATHE_BUILT || (i_cmd_mode != MODE_BREATHE);

    // A rejected command must not disturb the running pattern, so the
    // prescaler is only cleared when APPLY installs a mode.
    assign presc_clear = (state_q == ST_APPLY) && apply_ok_q;

    led_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (presc_clear),
        .o_tick    (tick)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        apply_ok_d = apply_ok_q;
        err_d      = 1'b0;
        tick_cnt_d = tick_cnt_q;
        phase_d    = phase_q;
        blank      = 1'b0;
        led_d      = 1'b0;
`ifdef LED_BREATHE_EN
        pwm_d      = pwm_q + 1'b1;
        duty_d     = duty_q;
        dir_up_d   = dir_up_q;
`endif

        // Pattern timing runs independently of the command FSM.
        if (tick && (mode_q == MODE_BLINK)) begin
            if (tick_cnt_q == TW'(BLINK_TICKS - 1)) begin
                tick_cnt_d = '0;
                phase_d    = ~phase_q;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end

`ifdef LED_BREATHE_EN
        // Direction flips on the tick that lands on an endpoint, so duty
        // never overshoots or wraps.
        if (tick && (mode_q == MODE_BREATHE)) begin
            if (dir_up_q) begin
                duty_d = duty_q + 1'b1;
                if (duty_d == '1) begin
                    dir_up_d = 1'b0;
                end
            end else begin
                duty_d = duty_q - 1'b1;
                if (duty_d == '0) begin
                    dir_up_d = 1'b1;
                end
            end
        end
`endif

        case (state_q)
            ST_RUN: begin
                if (i_cmd_valid) begin
                    state_d    = ST_APPLY;
                    apply_ok_d = cmd_supported;
                    err_d      = !cmd_supported;
                    if (cmd_supported) begin
                        mode_d = led_mode_t'(i_cmd_mode);
                    end
                end
            end
            ST_APPLY: begin
                state_d = ST_RUN;
                // Restart the pattern from its initial state; re-sending the
                // active mode lands here too.
                if (apply_ok_q) begin
                    tick_cnt_d = '0;
                    phase_d    = 1'b1;
`ifdef LED_BREATHE_EN
                    pwm_d      = '0;
                    duty_d     = '0;
                    dir_up_d   = 1'b1;
`endif
                end
            end
            default: state_d = ST_RUN;
        endcase

        // o_led is registered from next-state values so it lines up with
        // the pattern state it represents.
        blank = (state_d == ST_APPLY) && apply_ok_d;
        if (!blank) begin
            case (mode_d)
                MODE_ON:      led_d = 1'b1;
                MODE_BLINK:   led_d = phase_d;
`ifdef LED_BREATHE_EN
                MODE_BREATHE: led_d = (pwm_d < duty_d);
`endif
                default:      led_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_RUN;
            mode_q     <= MODE_OFF;
            apply_ok_q <= 1'b0;
            err_q      <= 1'b0;
            led_q      <= 1'b0;
            tick_cnt_q <= '0;
            phase_q    <= 1'b0;
`ifdef LED_BREATHE_EN
            pwm_q      <= '0;
            duty_q     <= '0;
            dir_up_q   <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            apply_ok_q <= apply_ok_d;
            err_q      <= err_d;
            led_q      <= led_d;
            tick_cnt_q <= tick_cnt_d;
            phase_q    <= phase_d;
`ifdef LED_BREATHE_EN
            pwm_q      <= pwm_d;
            duty_q     <= duty_d;
            dir_up_q   <= dir_up_d;
`endif
        end
    end

    assign o_cmd_ready = (state_q == ST_RUN);
    assign o_led       = led_q;
    assign o_gnd       = 1'b0;
    assign o_mode      = mode_q;
    assign o_err       = err_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
//   Self-checking bench for led_pattern_gen with PRESCALE=4, BLINK_TICKS=3,
//   PWM_BITS=3. Inputs change and outputs are sampled on the falling edge;
//   the DUT updates on the rising edge. Expected o_led sequences come from
//   closed-form models of the waveforms (t = cycles since APPLY ended).
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;
    import led_pkg::*;

    localparam int PRESCALE    = 4;
    localparam int BLINK_TICKS = 3;
    localparam int PWM_BITS    = 3;
    localparam int HALF        = PRESCALE * BLINK_TICKS;
    localparam int DMAX        = (1 << PWM_BITS) - 1;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic       led;
    logic       gnd;
    logic [1:0] mode;
    logic       err;
    led_state_t dbg_state;

    int errors;
    int checks;
    logic [0:0] exp_q[$];

    led_pattern_gen #(
        .PRESCALE    (PRESCALE),
        .BLINK_TICKS (BLINK_TICKS),
        .PWM_BITS    (PWM_BITS)
    ) dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_mode  (cmd_mode),
        .o_led       (led),
        .o_gnd       (gnd),
        .o_mode      (mode),
        .o_err       (err),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- reference waveforms ----------------
    function automatic logic blink_exp(input int t);
        return ((t / HALF) % 2) == 0;
    endfunction

`ifdef LED_BREATHE_EN
    function automatic logic breathe_exp(input int t);
        int m;
        int duty;
        m    = (t / PRESCALE) % (2 * DMAX);
        duty = (m <= DMAX) ? m : (2 * DMAX - m);
        return (t % (1 << PWM_BITS)) < duty;
    endfunction
`endif

    // ---------------- driver ----------------
    // Called at a falling edge: presents a command, lets the next rising
    // edge accept it and returns at the falling edge inside APPLY.
    task automatic drive_cmd(input logic [1:0] m);
        cmd_mode  = m;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        repeat (3) @(negedge clk);
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL reset_led: got %0b expected 0", led); end
        checks++; if (gnd !== 1'b0) begin errors++; $display("FAIL reset_gnd: got %0b expected 0", gnd); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", mode); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", cmd_ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
        checks++; if (dbg_state !== ST_RUN) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_RUN); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %0b expected 1", cmd_ready); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL idle_led: got %0b expected 0", led); end
    endtask

    task automatic test_handshake();
        cmd_mode  = 2'd1;
        cmd_valid = 1'b1;
        @(negedge clk);
        // In APPLY: keep a spurious request alive across the edge that ends it.
        cmd_mode  = 2'd2;
        cmd_valid = 1'b1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL hs_apply_ready: got %0b expected 0", cmd_ready); end
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL hs_apply_mode: got %0d expected 1", mode); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL hs_apply_led: got %0b expected 0", led); end
        checks++; if (dbg_state !== ST_APPLY) begin errors++; $display("FAIL hs_apply_state: got %0d expected %0d", dbg_state, ST_APPLY); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL hs_apply_err: got %0b expected 0", err); end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL hs_run_ready: got %0b expected 1", cmd_ready); end
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL hs_on_led: got %0b expected 1", led); end
        @(negedge clk);
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL hs_ignored_mode: got %0d expected 1", mode); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL hs_ignored_ready: got %0b expected 1", cmd_ready); end
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL hs_on_led2: got %0b expected 1", led); end
    endtask

    task automatic test_blink();
        logic [0:0] e;
        for (int t = 0; t < 18; t++) exp_q.push_back(blink_exp(t));
        drive_cmd(2'd2);
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL blink_apply_led: got %0b expected 0", led); end
        checks++; if (mode !== 2'd2) begin errors++; $display("FAIL blink_apply_mode: got %0d expected 2", mode); end
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (led !== e) begin errors++; $display("FAIL blink_led: got %0b expected %0b", led, e); end
        end
        // Now in the low half; re-sending BLINK restarts with a full high half.
        for (int t = 0; t < 2 * HALF + 5; t++) exp_q.push_back(blink_exp(t));
        drive_cmd(2'd2);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL blink_restart_ready: got %0b expected 0", cmd_ready); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL blink_restart_apply_led: got %0b expected 0", led); end
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (led !== e) begin errors++; $display("FAIL blink_restart_led: got %0b expected %0b", led, e); end
        end
        // LED is high here; an asynchronous reset must clear it without an edge.
        rst_n = 1'b0;
        #1;
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL async_reset_led: got %0b expected 0", led); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL async_reset_mode: got %0d expected 0", mode); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready: got %0b expected 1", cmd_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef LED_BREATHE_EN
    task automatic test_breathe();
        logic [0:0] e;
        for (int t = 0; t < 2 * PRESCALE * 2 * DMAX; t++) exp_q.push_back(breathe_exp(t));
        drive_cmd(2'd3);
        checks++; if (mode !== 2'd3) begin errors++; $display("FAIL breathe_apply_mode: got %0d expected 3", mode); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL breathe_apply_led: got %0b expected 0", led); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL breathe_apply_err: got %0b expected 0", err); end
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (led !== e) begin errors++; $display("FAIL breathe_led: got %0b expected %0b", led, e); end
        end
    endtask
`else
    task automatic test_config_off();
        logic [0:0] e;
        for (int t = 0; t < 5; t++) exp_q.push_back(blink_exp(t));
        drive_cmd(2'd2);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (led !== e) begin errors++; $display("FAIL cfg_blink_pre_led: got %0b expected %0b", led, e); end
        end
        // t=4 now; the rejected command's APPLY is t=5 and blink keeps running.
        drive_cmd(2'd3);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL cfg_err_pulse: got %0b expected 1", err); end
        checks++; if (mode !== 2'd2) begin errors++; $display("FAIL cfg_apply_mode: got %0d expected 2", mode); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL cfg_apply_ready: got %0b expected 0", cmd_ready); end
        checks++; if (led !== blink_exp(5)) begin errors++; $display("FAIL cfg_apply_led: got %0b expected %0b", led, blink_exp(5)); end
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL cfg_err_width: got %0b expected 0", err); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cfg_run_ready: got %0b expected 1", cmd_ready); end
        checks++; if (mode !== 2'd2) begin errors++; $display("FAIL cfg_run_mode: got %0d expected 2", mode); end
        for (int t = 7; t <= 30; t++) exp_q.push_back(blink_exp(t));
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (led !== e) begin errors++; $display("FAIL cfg_blink_post_led: got %0b expected %0b", led, e); end
        end
    endtask
`endif

    task automatic test_off();
        logic [0:0] e;
        for (int t = 0; t < 20; t++) exp_q.push_back(1'b0);
        drive_cmd(2'd0);
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL off_apply_mode: got %0d expected 0", mode); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL off_apply_led: got %0b expected 0", led); end
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (led !== e) begin errors++; $display("FAIL off_led: got %0b expected %0b", led, e); end
        end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL off_final_mode: got %0d expected 0", mode); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        test_reset();
        test_handshake();
        test_blink();
`ifdef LED_BREATHE_EN
        test_breathe();
`else
        test_config_off();
`endif
        test_off();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
